// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding access to a fixed-latency data memory, big-endian lanes.
// Optional macro MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module load_store_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_width,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] d_addr,
  output logic        d_enable,
  output logic        d_write,
  output logic [1:0]  data_width,
  output logic [31:0] d_wdata,
  input  logic [31:0] d_rdata
);

  // state  | meaning
  // IDLE   | ready for a request
  // ACCESS | memory port driven, latency counter running
  // RESP   | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  width_q, width_d;
  logic        write_q, write_d;
  logic        signed_q, signed_d;
  logic        error_q, error_d;

  logic        bad_req;
  logic [31:0] addr_fix;
  logic [31:0] wdata_fix;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      width_q  <= '0;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      width_q  <= width_d;
      write_q  <= write_d;
      signed_q <= signed_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
`ifdef MISALIGN_TRAP_EN
    bad_req = (req_width == 2'b11) ||
              (req_width == 2'b01 && req_addr[0]) ||
              (req_width == 2'b10 && req_addr[1:0] != 2'b00);
`else
    bad_req = (req_width == 2'b11);
`endif
    // Misaligned low bits are dropped so address and lane select agree.
    addr_fix = req_addr;
    if (req_width == 2'b01) addr_fix[0] = 1'b0;
    if (req_width == 2'b10) addr_fix[1:0] = 2'b00;
    unique case (req_width)
      2'b00:   wdata_fix = {4{req_wdata[7:0]}};
      2'b01:   wdata_fix = {2{req_wdata[15:0]}};
      default: wdata_fix = req_wdata;
    endcase
  end

  always_comb begin
    unique case (addr_q[1:0])
      2'd0:    lane_b = d_rdata[31:24];
      2'd1:    lane_b = d_rdata[23:16];
      2'd2:    lane_b = d_rdata[15:8];
      default: lane_b = d_rdata[7:0];
    endcase
    lane_h = addr_q[1] ? d_rdata[15:0] : d_rdata[31:16];
    unique case (width_q)
      2'b00:   load_ext = signed_q ? {{24{lane_b[7]}}, lane_b} : {24'd0, lane_b};
      2'b01:   load_ext = signed_q ? {{16{lane_h[15]}}, lane_h} : {16'd0, lane_h};
      default: load_ext = d_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    width_d  = width_q;
    write_d  = write_q;
    signed_d = signed_q;
    error_d  = error_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = addr_fix;
          wdata_d  = wdata_fix;
          width_d  = req_width;
          write_d  = req_write;
          signed_d = req_signed;
          if (bad_req) begin
            state_d = RESP;
            error_d = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ACCESS;
            error_d = 1'b0;
            cnt_d   = 4'(MEM_LATENCY - 1);
          end
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          rdata_d = write_q ? 32'd0 : load_ext;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_error = 1'b0;
    d_addr     = '0;
    d_enable   = 1'b0;
    d_write    = 1'b0;
    data_width = '0;
    d_wdata    = '0;
    unique case (state_q)
      IDLE: req_ready = 1'b1;
      ACCESS: begin
        d_enable   = 1'b1;
        d_addr     = addr_q;
        d_write    = write_q;
        data_width = width_q;
        d_wdata    = wdata_q;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_error = error_q;
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (latency 1 and 3) share request inputs and
// are compared against an arithmetic model of lane selection, extension and timing.
module tb_load_store_unit;
  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_width;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rd_val;

  logic        o_ready[2];
  logic        o_rvalid[2];
  logic [31:0] o_rdata[2];
  logic        o_err[2];
  logic [31:0] o_addr[2];
  logic        o_en[2];
  logic        o_write[2];
  logic [1:0]  o_width[2];
  logic [31:0] o_wdata[2];
  logic [31:0] mem_rd[2];

  int n_checks = 0;
  int n_pass = 0;

  // Memory only presents the real word while the port is enabled.
  assign mem_rd[0] = o_en[0] ? rd_val : ~rd_val;
  assign mem_rd[1] = o_en[1] ? rd_val : ~rd_val;

  load_store_unit #(.MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(o_ready[0]),
    .req_write(req_write), .req_width(req_width), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(o_rvalid[0]),
    .resp_rdata(o_rdata[0]), .resp_error(o_err[0]), .d_addr(o_addr[0]),
    .d_enable(o_en[0]), .d_write(o_write[0]), .data_width(o_width[0]),
    .d_wdata(o_wdata[0]), .d_rdata(mem_rd[0]));

  load_store_unit #(.MEM_LATENCY(3)) dut_l3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(o_ready[1]),
    .req_write(req_write), .req_width(req_width), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(o_rvalid[1]),
    .resp_rdata(o_rdata[1]), .resp_error(o_err[1]), .d_addr(o_addr[1]),
    .d_enable(o_en[1]), .d_write(o_write[1]), .data_width(o_width[1]),
    .d_wdata(o_wdata[1]), .d_rdata(mem_rd[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_width = 2'b00; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; rd_val = 32'd0;
    #3;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (o_ready[i] !== 1'b1 || o_rvalid[i] !== 1'b0 || o_rdata[i] !== 32'd0 ||
          o_err[i] !== 1'b0 || o_en[i] !== 1'b0 || o_write[i] !== 1'b0 ||
          o_addr[i] !== 32'd0 || o_width[i] !== 2'd0 || o_wdata[i] !== 32'd0)
        $display("FAIL reset_state dut%0d: ready=%b rv=%b rd=%h err=%b en=%b wr=%b addr=%h w=%b wd=%h, want ready=1 rest 0",
                 i, o_ready[i], o_rvalid[i], o_rdata[i], o_err[i], o_en[i], o_write[i],
                 o_addr[i], o_width[i], o_wdata[i]);
      else n_pass++;
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_txn(input string name, input logic wr, input logic [1:0] w,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input bit hold);
    logic        legal;
    logic [31:0] exp_addr, exp_wd, v, exp_rd;
    int          off;
    int          en_cnt[2], resp_cnt[2], resp_j[2], bad_cnt[2];
    logic [31:0] cap_addr[2], cap_wd[2], got_rd[2];
    logic        cap_wr[2], got_err[2], stable[2];
    logic [1:0]  cap_w[2];
    bit          dropped;

    legal = (w != 2'b11);
`ifdef MISALIGN_TRAP_EN
    if ((w == 2'b01 && a[0]) || (w == 2'b10 && a[1:0] != 2'b00)) legal = 1'b0;
`endif
    exp_addr = (w == 2'b10) ? a - (a % 4) : (w == 2'b01) ? a - (a % 2) : a;
    exp_wd   = (w == 2'b00) ? {24'd0, wd[7:0]} * 32'h01010101 :
               (w == 2'b01) ? {16'd0, wd[15:0]} * 32'h00010001 : wd;
    if (w == 2'b00) begin
      off = int'(a % 4);
      v = (rd >> (8 * (3 - off))) & 32'hFF;
      if (sg && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else if (w == 2'b01) begin
      off = int'((a / 2) % 2);
      v = (rd >> (16 * (1 - off))) & 32'hFFFF;
      if (sg && v >= 32'd32768) v = v + 32'hFFFF0000;
    end else begin
      v = rd;
    end
    exp_rd = (legal && !wr) ? v : 32'd0;

    for (int i = 0; i < 2; i++) begin
      en_cnt[i] = 0; resp_cnt[i] = 0; resp_j[i] = -1; bad_cnt[i] = 0;
      stable[i] = 1'b1; got_rd[i] = 32'd0; got_err[i] = 1'b0;
      cap_addr[i] = 32'd0; cap_wd[i] = 32'd0; cap_wr[i] = 1'b0; cap_w[i] = 2'd0;
    end

    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_width = w; req_signed = sg;
    req_addr = a; req_wdata = wd; rd_val = rd;
    @(posedge clk);
    dropped = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (o_en[i]) begin
          if (en_cnt[i] == 0) begin
            cap_addr[i] = o_addr[i]; cap_wd[i] = o_wdata[i];
            cap_wr[i] = o_write[i]; cap_w[i] = o_width[i];
          end else if (o_addr[i] !== cap_addr[i] || o_wdata[i] !== cap_wd[i] ||
                       o_write[i] !== cap_wr[i] || o_width[i] !== cap_w[i]) begin
            stable[i] = 1'b0;
          end
          en_cnt[i]++;
        end else if (o_write[i]) begin
          bad_cnt[i]++;
        end
        if (o_rvalid[i]) begin
          resp_cnt[i]++;
          resp_j[i] = j;
          got_rd[i] = o_rdata[i];
          got_err[i] = o_err[i];
        end
      end
      // Fields scrambled after accept; a held request must not be taken while busy.
      if (o_rvalid[0]) dropped = 1'b1;
      if (!hold || dropped) req_valid = 1'b0;
      req_width = 2'($urandom_range(0, 3));
      req_write = 1'($urandom_range(0, 1));
      req_addr = $urandom;
      req_wdata = $urandom;
    end
    req_valid = 1'b0;

    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (en_cnt[i] !== (legal ? lat_of(i) : 0))
        $display("FAIL %s dut%0d enable_cycles: got %0d want %0d", name, i, en_cnt[i], legal ? lat_of(i) : 0);
      else n_pass++;
      n_checks++;
      if (resp_cnt[i] !== 1)
        $display("FAIL %s dut%0d resp_count: got %0d want 1", name, i, resp_cnt[i]);
      else n_pass++;
      n_checks++;
      if (resp_j[i] + 1 !== (legal ? lat_of(i) + 1 : 1))
        $display("FAIL %s dut%0d resp_edge: got %0d want %0d", name, i, resp_j[i] + 1, legal ? lat_of(i) + 1 : 1);
      else n_pass++;
      n_checks++;
      if (got_rd[i] !== exp_rd)
        $display("FAIL %s dut%0d resp_rdata: got %h want %h", name, i, got_rd[i], exp_rd);
      else n_pass++;
      n_checks++;
      if (got_err[i] !== !legal)
        $display("FAIL %s dut%0d resp_error: got %b want %b", name, i, got_err[i], !legal);
      else n_pass++;
      n_checks++;
      if (bad_cnt[i] !== 0 || o_ready[i] !== 1'b1)
        $display("FAIL %s dut%0d idle_state: stray_write=%0d ready=%b want 0/1", name, i, bad_cnt[i], o_ready[i]);
      else n_pass++;
      if (legal) begin
        n_checks++;
        if (cap_addr[i] !== exp_addr || cap_w[i] !== w || cap_wr[i] !== wr || stable[i] !== 1'b1)
          $display("FAIL %s dut%0d port_drive: addr=%h w=%b wr=%b stable=%b want %h %b %b 1",
                   name, i, cap_addr[i], cap_w[i], cap_wr[i], stable[i], exp_addr, w, wr);
        else n_pass++;
        if (wr) begin
          n_checks++;
          if (cap_wd[i] !== exp_wd)
            $display("FAIL %s dut%0d d_wdata: got %h want %h", name, i, cap_wd[i], exp_wd);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_directed();
    do_txn("ld_word", 1'b0, 2'b10, 1'b0, 32'h00010000, 32'd0, 32'h8C220004, 1'b0);
    do_txn("ld_byte_s", 1'b0, 2'b00, 1'b1, 32'h00010001, 32'd0, 32'h1280FF00, 1'b0);
    do_txn("ld_byte_u", 1'b0, 2'b00, 1'b0, 32'h00010001, 32'd0, 32'h1280FF00, 1'b0);
    do_txn("st_half", 1'b1, 2'b01, 1'b0, 32'h00010002, 32'h0000BEEF, 32'h12345678, 1'b0);
    do_txn("ld_half_hi_s", 1'b0, 2'b01, 1'b1, 32'h00010002, 32'd0, 32'h1234F00D, 1'b0);
    do_txn("st_byte", 1'b1, 2'b00, 1'b0, 32'h00010003, 32'hAABBCC5A, 32'd0, 1'b0);
    do_txn("ld_word_mis", 1'b0, 2'b10, 1'b0, 32'h00010002, 32'd0, 32'hCAFEBABE, 1'b0);
    do_txn("reserved_w", 1'b0, 2'b11, 1'b1, 32'h00010000, 32'd0, 32'hFFFFFFFF, 1'b0);
  endtask

  task automatic test_busy_ignore();
    do_txn("busy_hold", 1'b0, 2'b01, 1'b1, 32'h00020000, 32'd0, 32'h80017FFF, 1'b1);
    do_txn("busy_hold_st", 1'b1, 2'b10, 1'b0, 32'h00020004, 32'h01234567, 32'd0, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++)
      do_txn("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
  endtask

  task automatic test_reset_in_access();
    int stray;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_width = 2'b10; req_signed = 1'b0;
    req_addr = 32'h00010000; rd_val = 32'h55AA55AA;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_en[1] !== 1'b1)
      $display("FAIL rst_access pre_enable: got %b want 1", o_en[1]);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if (o_en[1] !== 1'b0 || o_ready[1] !== 1'b1 || o_rvalid[1] !== 1'b0 || o_addr[1] !== 32'd0)
      $display("FAIL rst_access async: en=%b ready=%b rv=%b addr=%h want 0 1 0 0",
               o_en[1], o_ready[1], o_rvalid[1], o_addr[1]);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (o_rvalid[0] || o_rvalid[1] || o_en[0] || o_en[1]) stray++;
    end
    n_checks++;
    if (stray !== 0)
      $display("FAIL rst_access discarded: activity_cycles=%0d want 0", stray);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_random();
    test_reset_in_access();
    do_txn("after_reset", 1'b0, 2'b00, 1'b1, 32'h00000002, 32'd0, 32'h00007F00, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
